spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_ctrl_if.sv | 34 +++
 rtl/spi_cmd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: byte-stream input and register-bank write port bundle.
// Ports (slave = controller side):
//   SENABLE    in   raw SPI frame enable, low active, asynchronous
//   BYTE_VALID in   one-cycle strobe for a received byte
//   BYTE_DATA  in   received byte
//   REG_ACK    in   register-bank write acknowledge
//   REG_WE     out  write request, held until acked or timed out
//   REG_ADDR   out  write address (ADDR_W bits)
//   REG_WDATA  out  write data (16 bits)
//   BUSY       out  frame or write in progress
//   ERR        out  one-cycle error pulse
interface spi_cmd_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              SENABLE;
    logic              BYTE_VALID;
    logic [7:0]        BYTE_DATA;
    logic              REG_ACK;
    logic              REG_WE;
    logic [ADDR_W-1:0] REG_ADDR;
    logic [15:0]       REG_WDATA;
    logic              BUSY;
    logic              ERR;

    modport master (
        output SENABLE, BYTE_VALID, BYTE_DATA, REG_ACK,
        input  REG_WE, REG_ADDR, REG_WDATA, BUSY, ERR
    );

    modport slave (
        input  SENABLE, BYTE_VALID, BYTE_DATA, REG_ACK,
        output REG_WE, REG_ADDR, REG_WDATA, BUSY, ERR
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns a 3-byte SPI command frame (cmd, data hi, data lo)
// into a single register-bank write with ack handshake and ack timeout.
// Ports:
//   CLK    in  system clock, rising edge
//   RESET  in  asynchronous active-high reset
//   bus    spi_cmd_ctrl_if.slave (byte input, register write, BUSY, ERR)
// Parameters: ADDR_W (1..7) address width, ACK_TIMEOUT (1..65535) cycles.
// Optional: define SPI_CMD_CHECKSUM_EN for a 4th XOR checksum byte.
module spi_cmd_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RESET,
    spi_cmd_ctrl_if.slave bus
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_CMD,
        S_DHI,
        S_DLO,
        S_CHK,
        S_WAIT
    } state_e;

    state_e            state_q;
    logic              sen_meta_q;
    logic              sen_sync_q;
    logic              wr_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]        cks_q;
`endif

    assign bus.REG_WE    = we_q;
    assign bus.REG_ADDR  = addr_q;
    assign bus.REG_WDATA = wdata_q;
    assign bus.ERR       = err_q;
    assign bus.BUSY      = (state_q != S_CMD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_CMD;
            sen_meta_q <= 1'b1;
            sen_sync_q <= 1'b1;
            wr_q       <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
            cks_q      <= '0;
`endif
        end else begin
            sen_meta_q <= bus.SENABLE;
            sen_sync_q <= sen_meta_q;
            err_q      <= 1'b0;

            case (state_q)
                S_CMD: begin
                    // SENABLE high here (e.g. after a write) is harmless
                    if (bus.BYTE_VALID && !sen_sync_q) begin
                        wr_q    <= bus.BYTE_DATA[7];
                        addr_q  <= bus.BYTE_DATA[ADDR_W-1:0];
`ifdef SPI_CMD_CHECKSUM_EN
                        cks_q   <= bus.BYTE_DATA;
`endif
                        state_q <= S_DHI;
                    end
                end

                S_DHI: begin
                    // frame end beats a coincident byte
                    if (sen_sync_q) begin
                        err_q   <= 1'b1;
                        state_q <= S_CMD;
                    end else if (bus.BYTE_VALID) begin
                        wdata_q[15:8] <= bus.BYTE_DATA;
`ifdef SPI_CMD_CHECKSUM_EN
                        cks_q         <= cks_q ^ bus.BYTE_DATA;
`endif
                        state_q       <= S_DLO;
                    end
                end

                S_DLO: begin
                    if (sen_sync_q) begin
                        err_q   <= 1'b1;
                        state_q <= S_CMD;
                    end else if (bus.BYTE_VALID) begin
                        wdata_q[7:0] <= bus.BYTE_DATA;
`ifdef SPI_CMD_CHECKSUM_EN
                        cks_q        <= cks_q ^ bus.BYTE_DATA;
                        state_q      <= S_CHK;
`else
                        if (wr_q) begin
                            we_q    <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_CMD;
                        end
`endif
                    end
                end

`ifdef SPI_CMD_CHECKSUM_EN
                S_CHK: begin
                    if (sen_sync_q) begin
                        err_q   <= 1'b1;
                        state_q <= S_CMD;
                    end else if (bus.BYTE_VALID) begin
                        if (bus.BYTE_DATA != cks_q) begin
                            err_q   <= 1'b1;
                            state_q <= S_CMD;
                        end else if (wr_q) begin
                            we_q    <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_CMD;
                        end
                    end
                end
`endif

                S_WAIT: begin
                    // a byte arriving mid-write is dropped and flagged
                    if (bus.BYTE_VALID) begin
                        err_q <= 1'b1;
                    end
                    if (bus.REG_ACK) begin
                        we_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_CMD;
                    end else if (cnt_q == TO_LAST) begin
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_CMD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed frames for spi_cmd_ctrl; expected writes and
// error pulses are queued by stimulus and consumed by a separate monitor.
module tb_spi_cmd_ctrl;

    localparam int AW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_cmd_ctrl_if #(.ADDR_W(AW)) bus ();

    spi_cmd_ctrl #(
        .ADDR_W      (AW),
        .ACK_TIMEOUT (TO)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cycles;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_err[$];
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(logic [7:0] b);
        @(posedge clk);
        #1;
        bus.BYTE_VALID = 1'b1;
        bus.BYTE_DATA  = b;
        @(posedge clk);
        #1;
        bus.BYTE_VALID = 1'b0;
    endtask

    task automatic frame(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
        logic [7:0] cks;
        cks = b0 ^ b1 ^ b2;
        bus.SENABLE = 1'b0;
        tick(3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
`ifdef SPI_CMD_CHECKSUM_EN
        send_byte(cks);
`endif
    endtask

    // monitor: consumes expectations whenever the DUT shows ERR or REG_WE
    initial begin
        wr_t  cur;
        int   hi_cnt;
        logic we_prev;
        cur     = '{addr: '0, data: '0, cycles: 0};
        hi_cnt  = 0;
        we_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ERR === 1'b1) begin
                check("err_expected", 32'(exp_err.size() > 0), 32'd1);
                if (exp_err.size() > 0) void'(exp_err.pop_front());
            end
            if (bus.REG_WE === 1'b1 && !we_prev) begin
                check("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) cur = exp_wr.pop_front();
                else cur = '{addr: '0, data: '0, cycles: 0};
                check("wr_addr", 32'(bus.REG_ADDR), 32'(cur.addr));
                check("wr_data", 32'(bus.REG_WDATA), 32'(cur.data));
                hi_cnt = 1;
            end else if (bus.REG_WE === 1'b1) begin
                hi_cnt++;
                check("wr_addr_hold", 32'(bus.REG_ADDR), 32'(cur.addr));
                check("wr_data_hold", 32'(bus.REG_WDATA), 32'(cur.data));
            end else if (we_prev) begin
                check("wr_cycles", 32'(hi_cnt), 32'(cur.cycles));
            end
            we_prev = (bus.REG_WE === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.SENABLE    = 1'b1;
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_DATA  = 8'h00;
        bus.REG_ACK    = 1'b0;

        @(negedge clk);
        check("rst_we",    32'(bus.REG_WE),    32'd0);
        check("rst_addr",  32'(bus.REG_ADDR),  32'd0);
        check("rst_wdata", 32'(bus.REG_WDATA), 32'd0);
        check("rst_busy",  32'(bus.BUSY),      32'd0);
        check("rst_err",   32'(bus.ERR),       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);

        // write, ack on 2nd REG_WE cycle
        exp_wr.push_back('{addr: 4'd3, data: 16'h1234, cycles: 2});
        frame(8'h83, 8'h12, 8'h34);
        @(negedge clk);
        check("latency_we", 32'(bus.REG_WE), 32'd1);
        check("wait_busy",  32'(bus.BUSY),   32'd1);
        @(posedge clk);
        #1 bus.REG_ACK = 1'b1;
        @(posedge clk);
        #1 bus.REG_ACK = 1'b0;
        bus.SENABLE = 1'b1;
        tick(3);
        check("a_busy", 32'(bus.BUSY), 32'd0);

        // read frame: no write, no error
        frame(8'h05, 8'hAA, 8'h55);
        @(negedge clk);
        check("rd_busy", 32'(bus.BUSY),   32'd0);
        check("rd_we",   32'(bus.REG_WE), 32'd0);
        bus.SENABLE = 1'b1;
        tick(3);

        // abort after two bytes, then a good frame
        exp_err.push_back(1);
        bus.SENABLE = 1'b0;
        tick(3);
        send_byte(8'h81);
        send_byte(8'h10);
        bus.SENABLE = 1'b1;
        tick(4);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        exp_wr.push_back('{addr: 4'd2, data: 16'h0001, cycles: 1});
        frame(8'h82, 8'h00, 8'h01);
        bus.REG_ACK = 1'b1;
        tick(1);
        bus.REG_ACK = 1'b0;
        bus.SENABLE = 1'b1;
        tick(3);

        // ack timeout; SENABLE rising during wait has no effect
        exp_wr.push_back('{addr: 4'hF, data: 16'hBEEF, cycles: TO});
        exp_err.push_back(1);
        frame(8'h8F, 8'hBE, 8'hEF);
        bus.SENABLE = 1'b1;
        tick(12);
        check("to_busy", 32'(bus.BUSY),   32'd0);
        check("to_we",   32'(bus.REG_WE), 32'd0);

        // byte during wait is dropped with ERR, write still completes
        exp_wr.push_back('{addr: 4'd4, data: 16'h0007, cycles: 3});
        exp_err.push_back(1);
        frame(8'h84, 8'h00, 8'h07);
        send_byte(8'hFF);
        bus.REG_ACK = 1'b1;
        tick(1);
        bus.REG_ACK = 1'b0;
        bus.SENABLE = 1'b1;
        tick(3);
        check("drop_wdata", 32'(bus.REG_WDATA), 32'h0007);

        // byte while idle and SENABLE high is ignored
        send_byte(8'h8A);
        tick(2);
        check("idle_ign_busy", 32'(bus.BUSY), 32'd0);

        // abort and byte in the same cycle: abort wins
        exp_err.push_back(1);
        bus.SENABLE = 1'b0;
        tick(3);
        send_byte(8'h81);
        bus.SENABLE = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.BYTE_VALID = 1'b1;
        bus.BYTE_DATA  = 8'h22;
        @(posedge clk);
        #1 bus.BYTE_VALID = 1'b0;
        tick(2);
        check("race_wdata", 32'(bus.REG_WDATA), 32'h0007);
        check("race_busy",  32'(bus.BUSY),      32'd0);

`ifdef SPI_CMD_CHECKSUM_EN
        exp_err.push_back(1);
        bus.SENABLE = 1'b0;
        tick(3);
        send_byte(8'h81);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        bus.SENABLE = 1'b1;
        tick(3);
        check("cks_bad_busy", 32'(bus.BUSY), 32'd0);
        exp_wr.push_back('{addr: 4'd1, data: 16'h0001, cycles: 1});
        bus.SENABLE = 1'b0;
        tick(3);
        send_byte(8'h81);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h80);
        bus.REG_ACK = 1'b1;
        tick(1);
        bus.REG_ACK = 1'b0;
        bus.SENABLE = 1'b1;
        tick(3);
`endif

        // reset while REG_WE is high
        exp_wr.push_back('{addr: 4'd6, data: 16'h55AA, cycles: 1});
        frame(8'h86, 8'h55, 8'hAA);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_we",    32'(bus.REG_WE),    32'd0);
        check("mid_rst_addr",  32'(bus.REG_ADDR),  32'd0);
        check("mid_rst_wdata", 32'(bus.REG_WDATA), 32'd0);
        check("mid_rst_busy",  32'(bus.BUSY),      32'd0);
        check("mid_rst_err",   32'(bus.ERR),       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.SENABLE = 1'b1;
        tick(5);

        check("wr_queue_empty",  32'(exp_wr.size()),  32'd0);
        check("err_queue_empty", 32'(exp_err.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
